// File: rtl/tod_pkg.sv
// Shared types, limits and display helpers for the time-of-day counter.
package tod_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef enum logic {ALM_IDLE, ALM_RING} alm_state_e;

  // 24h hour (0..23) to 12h face value (1..12).
  function automatic logic [4:0] hr_to_12h(input logic [4:0] hr);
    if (hr == 5'd0) begin
      return 5'd12;
    end else if (hr > 5'd12) begin
      return hr - 5'd12;
    end else begin
      return hr;
    end
  endfunction

  // Binary 0..59 to packed {tens, units} BCD.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    bcd_t tens;
    bcd_t units;
    if (v >= 6'd50)      tens = 4'd5;
    else if (v >= 6'd40) tens = 4'd4;
    else if (v >= 6'd30) tens = 4'd3;
    else if (v >= 6'd20) tens = 4'd2;
    else if (v >= 6'd10) tens = 4'd1;
    else                 tens = 4'd0;
    units = 4'(v - 6'(tens) * 6'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one tick_o per TICK_DIV enabled cycles; clr_i restarts
// the count and suppresses a coincident tick.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/time_of_day_core.sv
// 24h time-of-day counter with set pulses, 12/24h registered display and alarm.
//   state    | meaning
//   ALM_IDLE | waiting for an armed hh:mm match at a minute rollover
//   ALM_RING | alarm asserted; counts down ALARM_LEN ticks unless acked/disarmed
module time_of_day_core
  import tod_pkg::*;
#(
  parameter int TICK_DIV  = 100000000,
  parameter int ALARM_LEN = 60,
  parameter int ALARM_EN  = 1
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       clr_sec,
  input  logic [7:0] alm_hr,
  input  logic [7:0] alm_min,
  input  logic       alm_arm,
  input  logic       alm_ack,
  output logic [3:0] hr_u,
  output logic [3:0] hr_l,
  output logic [3:0] min_u,
  output logic [3:0] min_l,
  output logic [5:0] sec,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm
);

  localparam logic ALM_ON = (ALARM_EN != 0);

  logic       tick;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       sec_wrap, min_carry;
  logic [6:0] min_sum;
  logic [5:0] hr_sum;

  alm_state_e state_q, state_d;
  logic [7:0] alm_cnt_q, alm_cnt_d;
  logic [7:0] alm_hr_bin, alm_min_bin;
  logic       alm_valid, alm_match;

  logic [4:0] disp_hr;
  logic [7:0] hr_bcd, min_bcd;
  logic [3:0] hr_u_q, hr_l_q, min_u_q, min_l_q;
  logic [5:0] sec_out_q;
  logic       pm_q, sec_tick_q, alarm_q;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk_i (CLK100MHZ),
    .rst_i (RST),
    .en_i  (en),
    .clr_i (clr_sec),
    .tick_o(tick)
  );

  // Tick carries and button pulses are summed so a coincident pair advances by 2.
  always_comb begin
    sec_wrap  = tick && (sec_q == 6'(SEC_MAX));
    min_carry = sec_wrap && (min_q == 6'(MIN_MAX));

    if (clr_sec)       sec_d = '0;
    else if (sec_wrap) sec_d = '0;
    else if (tick)     sec_d = sec_q + 6'd1;
    else               sec_d = sec_q;

    min_sum = 7'(min_q) + 7'(sec_wrap) + 7'(inc_min);
    min_d   = (min_sum > 7'(MIN_MAX)) ? 6'(min_sum - 7'(MIN_MAX + 1)) : min_sum[5:0];

    hr_sum = 6'(hr_q) + 6'(min_carry) + 6'(inc_hr);
    hr_d   = (hr_sum > 6'(HR_MAX)) ? 5'(hr_sum - 6'(HR_MAX + 1)) : hr_sum[4:0];
  end

  always_comb begin
    alm_hr_bin  = 8'(alm_hr[7:4]) * 8'd10 + 8'(alm_hr[3:0]);
    alm_min_bin = 8'(alm_min[7:4]) * 8'd10 + 8'(alm_min[3:0]);
    alm_valid   = (alm_hr[7:4] <= 4'd2) && (alm_hr[3:0] <= 4'd9) &&
                  (alm_min[7:4] <= 4'd5) && (alm_min[3:0] <= 4'd9) &&
                  (alm_hr_bin <= 8'(HR_MAX));
    alm_match   = ALM_ON && alm_arm && alm_valid && sec_wrap &&
                  (8'(hr_d) == alm_hr_bin) && (8'(min_d) == alm_min_bin);
  end

  always_comb begin
    state_d   = state_q;
    alm_cnt_d = alm_cnt_q;
    case (state_q)
      ALM_IDLE: begin
        if (alm_match && !alm_ack) begin
          state_d   = ALM_RING;
          alm_cnt_d = 8'(ALARM_LEN);
        end
      end
      ALM_RING: begin
        if (alm_ack || !alm_arm) begin
          state_d = ALM_IDLE;
        end else if (tick) begin
          alm_cnt_d = alm_cnt_q - 8'd1;
          if (alm_cnt_q == 8'd1) state_d = ALM_IDLE;
        end
      end
      default: state_d = ALM_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      state_q   <= ALM_IDLE;
      alm_cnt_q <= '0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      state_q   <= state_d;
      alm_cnt_q <= alm_cnt_d;
    end
  end

  always_comb begin
    disp_hr = mode_12h ? hr_to_12h(hr_q) : hr_q;
    hr_bcd  = bin_to_bcd({1'b0, disp_hr});
    min_bcd = bin_to_bcd(min_q);
  end

  // Display registers reset straight to the 00:00:00 face for the current mode.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      hr_u_q     <= mode_12h ? 4'd1 : 4'd0;
      hr_l_q     <= mode_12h ? 4'd2 : 4'd0;
      min_u_q    <= '0;
      min_l_q    <= '0;
      sec_out_q  <= '0;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      hr_u_q     <= hr_bcd[7:4];
      hr_l_q     <= hr_bcd[3:0];
      min_u_q    <= min_bcd[7:4];
      min_l_q    <= min_bcd[3:0];
      sec_out_q  <= sec_q;
      pm_q       <= (hr_q >= 5'd12);
      sec_tick_q <= tick;
      alarm_q    <= ALM_ON && (state_d == ALM_RING);
    end
  end

  assign hr_u     = hr_u_q;
  assign hr_l     = hr_l_q;
  assign min_u    = min_u_q;
  assign min_l    = min_l_q;
  assign sec      = sec_out_q;
  assign pm       = pm_q;
  assign sec_tick = sec_tick_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_time_of_day_core.sv
// Directed bench for time_of_day_core with a 4-cycle tick and a 3-tick alarm.
module tb_time_of_day_core;

  logic       clk = 1'b0;
  logic       rst, en, mode_12h, inc_hr, inc_min, clr_sec, alm_arm, alm_ack;
  logic [7:0] alm_hr, alm_min;
  logic [3:0] hr_u, hr_l, min_u, min_l;
  logic [5:0] sec;
  logic       pm, sec_tick, alarm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_of_day_core #(.TICK_DIV(4), .ALARM_LEN(3), .ALARM_EN(1)) dut (
    .CLK100MHZ(clk), .RST(rst), .en(en), .mode_12h(mode_12h),
    .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec),
    .alm_hr(alm_hr), .alm_min(alm_min), .alm_arm(alm_arm), .alm_ack(alm_ack),
    .hr_u(hr_u), .hr_l(hr_l), .min_u(min_u), .min_l(min_l), .sec(sec),
    .pm(pm), .sec_tick(sec_tick), .alarm(alarm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string tag, input int hu, input int hl, input int mu,
                          input int ml, input int s);
    chk({tag, ".hr_u"}, 32'(hr_u), 32'(hu));
    chk({tag, ".hr_l"}, 32'(hr_l), 32'(hl));
    chk({tag, ".min_u"}, 32'(min_u), 32'(mu));
    chk({tag, ".min_l"}, 32'(min_l), 32'(ml));
    chk({tag, ".sec"}, 32'(sec), 32'(s));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_hr(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hr = 1'b1; step(); inc_hr = 1'b0; step();
    end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = 1'b1; step(); inc_min = 1'b0; step();
    end
  endtask

  // Returns at the sample right after the n-th sec_tick pulse.
  task automatic wait_ticks(input string tag, input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * 8 + 16) begin
      step();
      cyc++;
      if (sec_tick) seen++;
    end
    chk({tag, ".ticks"}, 32'(seen), 32'(n));
  endtask

  initial begin
    int cnt;
    int first;
    rst = 1'b1; en = 1'b0; mode_12h = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
    clr_sec = 1'b0; alm_arm = 1'b0; alm_ack = 1'b0; alm_hr = 8'h00; alm_min = 8'h00;

    // Reset state, both display modes
    step();
    chk_time("rst24", 0, 0, 0, 0, 0);
    chk("rst.pm", 32'(pm), 0);
    chk("rst.sec_tick", 32'(sec_tick), 0);
    chk("rst.alarm", 32'(alarm), 0);
    mode_12h = 1'b1;
    step();
    chk("rst12.hr_u", 32'(hr_u), 1);
    chk("rst12.hr_l", 32'(hr_l), 2);
    chk("rst12.pm", 32'(pm), 0);
    mode_12h = 1'b0;
    rst = 1'b0;
    en  = 1'b1;

    // Tick cadence and 240 seconds of free run
    cnt = 0; first = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (sec_tick) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("cadence.count", 32'(cnt), 4);
    chk("cadence.first", 32'(first), 4);
    wait_ticks("run240", 236);
    step();
    chk_time("t00_04_00", 0, 0, 0, 4, 0);

    // Day rollover
    do_reset();
    pulse_hr(23);
    pulse_min(59);
    step();
    chk_time("t23_59_00", 2, 3, 5, 9, 0);
    chk("t23_59_00.pm", 32'(pm), 1);
    en = 1'b1;
    wait_ticks("to59", 59);
    step();
    chk_time("t23_59_59", 2, 3, 5, 9, 59);
    mode_12h = 1'b1;
    step();
    chk("t23_12h.hr_u", 32'(hr_u), 1);
    chk("t23_12h.hr_l", 32'(hr_l), 1);
    chk("t23_12h.pm", 32'(pm), 1);
    wait_ticks("wrap", 1);
    step();
    chk_time("t12_00_00", 1, 2, 0, 0, 0);
    chk("t12_00_00.pm", 32'(pm), 0);
    mode_12h = 1'b0;

    // inc_min coincident with tick carry at 10:59:59
    do_reset();
    pulse_hr(10);
    pulse_min(59);
    en = 1'b1;
    wait_ticks("to10_59_59", 59);
    step(); step(); step();
    inc_min = 1'b1;
    step();
    inc_min = 1'b0;
    chk("coinc.sec_tick", 32'(sec_tick), 1);
    step();
    chk_time("t11_01_00", 1, 1, 0, 1, 0);

    // inc_min alone at 10:59:00 has no hour carry
    do_reset();
    pulse_hr(10);
    pulse_min(59);
    pulse_min(1);
    step();
    chk_time("t10_00_00", 1, 0, 0, 0, 0);

    // clr_sec on the tick cycle at sec=30
    en = 1'b1;
    wait_ticks("to30", 30);
    step(); step(); step();
    clr_sec = 1'b1;
    step();
    clr_sec = 1'b0;
    chk("clr.sec_tick", 32'(sec_tick), 0);
    step();
    chk_time("clr", 1, 0, 0, 0, 0);

    // Paused: no ticks, inc_hr still applies
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      inc_hr = (i == 5);
      step();
      if (sec_tick) cnt++;
    end
    inc_hr = 1'b0;
    chk("pause.ticks", 32'(cnt), 0);
    chk_time("pause", 1, 1, 0, 0, 0);

    // Alarm 07:30: set pulses never trigger, then rings and times out after 3 ticks
    do_reset();
    alm_hr = 8'h07; alm_min = 8'h30; alm_arm = 1'b1;
    pulse_hr(7);
    pulse_min(30);
    step();
    chk("setpulse.alarm", 32'(alarm), 0);
    pulse_min(59);
    en = 1'b1;
    wait_ticks("ring1", 60);
    chk("ring1.on", 32'(alarm), 1);
    step();
    chk_time("t07_30_00", 0, 7, 3, 0, 0);
    wait_ticks("ring1.two", 2);
    chk("ring1.still", 32'(alarm), 1);
    wait_ticks("ring1.three", 1);
    chk("ring1.timeout", 32'(alarm), 0);

    // Acknowledge one tick into the ring
    do_reset();
    pulse_hr(7);
    pulse_min(29);
    en = 1'b1;
    wait_ticks("ring2", 60);
    chk("ring2.on", 32'(alarm), 1);
    wait_ticks("ring2.one", 1);
    chk("ring2.before_ack", 32'(alarm), 1);
    alm_ack = 1'b1;
    step();
    alm_ack = 1'b0;
    chk("ring2.ack", 32'(alarm), 0);
    step();
    chk("ring2.stays_off", 32'(alarm), 0);

    // Disarm during ring
    do_reset();
    pulse_hr(7);
    pulse_min(29);
    en = 1'b1;
    wait_ticks("ring3", 60);
    chk("ring3.on", 32'(alarm), 1);
    alm_arm = 1'b0;
    step();
    chk("ring3.disarm", 32'(alarm), 0);
    alm_arm = 1'b1;

    // RST mid-ring at 07:30:02
    do_reset();
    pulse_hr(7);
    pulse_min(29);
    en = 1'b1;
    wait_ticks("ring4", 60);
    wait_ticks("ring4.two", 2);
    chk("ring4.on", 32'(alarm), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.alarm", 32'(alarm), 0);
    chk("midrst.sec_tick", 32'(sec_tick), 0);
    chk_time("midrst", 0, 0, 0, 0, 0);
    step();
    chk("midrst.after", 32'(alarm), 0);

    // Invalid minute digit 07:3A must not alias to 07:40
    do_reset();
    alm_hr = 8'h07; alm_min = 8'h3A;
    pulse_hr(7);
    pulse_min(39);
    en = 1'b1;
    wait_ticks("bad_min", 60);
    chk("bad_min.alarm", 32'(alarm), 0);
    step();
    chk_time("t07_40_00", 0, 7, 4, 0, 0);
    chk("bad_min.after", 32'(alarm), 0);

    // Hour 25 never matches
    do_reset();
    alm_hr = 8'h25; alm_min = 8'h00;
    pulse_hr(23);
    pulse_min(59);
    en = 1'b1;
    wait_ticks("bad_hr", 60);
    chk("bad_hr.alarm", 32'(alarm), 0);
    step();
    chk_time("bad_hr.t00", 0, 0, 0, 0, 0);
    chk("bad_hr.after", 32'(alarm), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
